// File: rtl/lane_vrf_write_arbiter.sv
// Round-robin arbiter sharing one lane VRF write port among NUM_REQ stage-3 write queues.
// Define VRF_WRITE_ARB_PERF_EN to add saturating grant/drop/stall performance counters.

module lane_vrf_write_arbiter_slot #(
    parameter int NUM_REQ = 4,
    parameter int IDX     = 0,
    parameter int SRC_W   = 2,
    parameter int MASK_W  = 4
) (
    input  logic [SRC_W-1:0]  ptr_i,
    input  logic [MASK_W-1:0] mask_i,
    output logic [SRC_W-1:0]  dist_o,
    output logic              mask_nz_o
);
    // Position of this requester in round-robin order starting at ptr; smallest valid distance wins.
    assign dist_o    = (SRC_W'(IDX) >= ptr_i) ? SRC_W'(IDX) - ptr_i
                                              : SRC_W'(IDX + NUM_REQ) - ptr_i;
    assign mask_nz_o = |mask_i;
endmodule

module lane_vrf_write_arbiter #(
    parameter  int NUM_REQ      = 4,
    parameter  int DATA_WIDTH   = 32,
    parameter  int OFFSET_WIDTH = 8,
    localparam int MASK_W       = DATA_WIDTH / 8,
    localparam int SRC_W        = $clog2(NUM_REQ)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [5*NUM_REQ-1:0]           req_vd,
    input  logic [OFFSET_WIDTH*NUM_REQ-1:0] req_offset,
    input  logic [MASK_W*NUM_REQ-1:0]      req_mask,
    input  logic [DATA_WIDTH*NUM_REQ-1:0]  req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    input  logic [3*NUM_REQ-1:0]           req_instructionIndex,
    input  logic                           vrfWriteRequest_ready,
    output logic                           vrfWriteRequest_valid,
    output logic [4:0]                     vrfWriteRequest_bits_vd,
    output logic [OFFSET_WIDTH-1:0]        vrfWriteRequest_bits_offset,
    output logic [MASK_W-1:0]              vrfWriteRequest_bits_mask,
    output logic [DATA_WIDTH-1:0]          vrfWriteRequest_bits_data,
    output logic                           vrfWriteRequest_bits_last,
    output logic [2:0]                     vrfWriteRequest_bits_instructionIndex,
    output logic [SRC_W-1:0]               grant_source
`ifdef VRF_WRITE_ARB_PERF_EN
   ,output logic [16*NUM_REQ-1:0]          perf_grant_count,
    output logic [15:0]                    perf_drop_count,
    output logic [15:0]                    perf_stall_count
`endif
);

    logic [NUM_REQ-1:0][4:0]              vd_w;
    logic [NUM_REQ-1:0][OFFSET_WIDTH-1:0] offset_w;
    logic [NUM_REQ-1:0][MASK_W-1:0]       mask_w;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   data_w;
    logic [NUM_REQ-1:0][2:0]              iidx_w;
    logic [NUM_REQ-1:0][SRC_W-1:0]        dist_w;
    logic [NUM_REQ-1:0]                   mask_nz_w;

    logic                    valid_q, valid_d;
    logic [4:0]              vd_q, vd_d;
    logic [OFFSET_WIDTH-1:0] offset_q, offset_d;
    logic [MASK_W-1:0]       mask_q, mask_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    last_q, last_d;
    logic [2:0]              iidx_q, iidx_d;
    logic [SRC_W-1:0]        src_q, src_d;
    logic [SRC_W-1:0]        ptr_q, ptr_d;

    logic             win_found;
    logic [SRC_W-1:0] win_idx;
    logic [SRC_W-1:0] win_dist;
    logic             can_load;
    logic             accept;
    logic             load;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign vd_w[i]     = req_vd[i*5 +: 5];
        assign offset_w[i] = req_offset[i*OFFSET_WIDTH +: OFFSET_WIDTH];
        assign mask_w[i]   = req_mask[i*MASK_W +: MASK_W];
        assign data_w[i]   = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        assign iidx_w[i]   = req_instructionIndex[i*3 +: 3];

        lane_vrf_write_arbiter_slot #(
            .NUM_REQ (NUM_REQ),
            .IDX     (i),
            .SRC_W   (SRC_W),
            .MASK_W  (MASK_W)
        ) u_slot (
            .ptr_i     (ptr_q),
            .mask_i    (mask_w[i]),
            .dist_o    (dist_w[i]),
            .mask_nz_o (mask_nz_w[i])
        );
    end

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_dist  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && (!win_found || dist_w[i] < win_dist)) begin
                win_found = 1'b1;
                win_idx   = SRC_W'(i);
                win_dist  = dist_w[i];
            end
        end
    end

    assign can_load  = ~valid_q | vrfWriteRequest_ready;
    assign accept    = win_found & can_load & ~reset;
    // Zero-mask writes are consumed here but never reach the VRF port.
    assign load      = accept & mask_nz_w[win_idx];
    assign req_ready = accept ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx) : '0;

    always_comb begin
        valid_d  = valid_q;
        vd_d     = vd_q;
        offset_d = offset_q;
        mask_d   = mask_q;
        data_d   = data_q;
        last_d   = last_q;
        iidx_d   = iidx_q;
        src_d    = src_q;
        ptr_d    = ptr_q;
        if (accept)
            ptr_d = (win_idx == SRC_W'(NUM_REQ - 1)) ? '0 : win_idx + SRC_W'(1);
        if (load) begin
            valid_d  = 1'b1;
            vd_d     = vd_w[win_idx];
            offset_d = offset_w[win_idx];
            mask_d   = mask_w[win_idx];
            data_d   = data_w[win_idx];
            last_d   = req_last[win_idx];
            iidx_d   = iidx_w[win_idx];
            src_d    = win_idx;
        end else if (vrfWriteRequest_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            vd_q     <= '0;
            offset_q <= '0;
            mask_q   <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
            iidx_q   <= '0;
            src_q    <= '0;
            ptr_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            vd_q     <= vd_d;
            offset_q <= offset_d;
            mask_q   <= mask_d;
            data_q   <= data_d;
            last_q   <= last_d;
            iidx_q   <= iidx_d;
            src_q    <= src_d;
            ptr_q    <= ptr_d;
        end
    end

    assign vrfWriteRequest_valid                 = valid_q;
    assign vrfWriteRequest_bits_vd               = vd_q;
    assign vrfWriteRequest_bits_offset           = offset_q;
    assign vrfWriteRequest_bits_mask             = mask_q;
    assign vrfWriteRequest_bits_data             = data_q;
    assign vrfWriteRequest_bits_last             = last_q;
    assign vrfWriteRequest_bits_instructionIndex = iidx_q;
    assign grant_source                          = src_q;

`ifdef VRF_WRITE_ARB_PERF_EN
    logic [NUM_REQ-1:0][15:0] grant_cnt_q;
    logic [15:0]              drop_cnt_q;
    logic [15:0]              stall_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant_cnt_q <= '0;
            drop_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (load && grant_cnt_q[win_idx] != 16'hFFFF)
                grant_cnt_q[win_idx] <= grant_cnt_q[win_idx] + 16'd1;
            if (accept && !mask_nz_w[win_idx] && drop_cnt_q != 16'hFFFF)
                drop_cnt_q <= drop_cnt_q + 16'd1;
            if (valid_q && !vrfWriteRequest_ready && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign perf_grant_count = grant_cnt_q;
    assign perf_drop_count  = drop_cnt_q;
    assign perf_stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_lane_vrf_write_arbiter.sv
// Self-checking bench for lane_vrf_write_arbiter: queue-free reference model plus directed vectors.
module tb_lane_vrf_write_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int OW = 8;
    localparam int MW = DW / 8;
    localparam int SW = $clog2(N);

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid, req_ready, req_last;
    logic [5*N-1:0] req_vd;
    logic [OW*N-1:0] req_offset;
    logic [MW*N-1:0] req_mask;
    logic [DW*N-1:0] req_data;
    logic [3*N-1:0] req_instructionIndex;
    logic           vrfWriteRequest_ready;
    logic           vrfWriteRequest_valid;
    logic [4:0]     vrfWriteRequest_bits_vd;
    logic [OW-1:0]  vrfWriteRequest_bits_offset;
    logic [MW-1:0]  vrfWriteRequest_bits_mask;
    logic [DW-1:0]  vrfWriteRequest_bits_data;
    logic           vrfWriteRequest_bits_last;
    logic [2:0]     vrfWriteRequest_bits_instructionIndex;
    logic [SW-1:0]  grant_source;
`ifdef VRF_WRITE_ARB_PERF_EN
    logic [16*N-1:0] perf_grant_count;
    logic [15:0]     perf_drop_count, perf_stall_count;
`endif

    lane_vrf_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .OFFSET_WIDTH(OW)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_vd(req_vd),
        .req_offset(req_offset), .req_mask(req_mask), .req_data(req_data),
        .req_last(req_last), .req_instructionIndex(req_instructionIndex),
        .vrfWriteRequest_ready(vrfWriteRequest_ready),
        .vrfWriteRequest_valid(vrfWriteRequest_valid),
        .vrfWriteRequest_bits_vd(vrfWriteRequest_bits_vd),
        .vrfWriteRequest_bits_offset(vrfWriteRequest_bits_offset),
        .vrfWriteRequest_bits_mask(vrfWriteRequest_bits_mask),
        .vrfWriteRequest_bits_data(vrfWriteRequest_bits_data),
        .vrfWriteRequest_bits_last(vrfWriteRequest_bits_last),
        .vrfWriteRequest_bits_instructionIndex(vrfWriteRequest_bits_instructionIndex),
        .grant_source(grant_source)
`ifdef VRF_WRITE_ARB_PERF_EN
       ,.perf_grant_count(perf_grant_count),
        .perf_drop_count(perf_drop_count),
        .perf_stall_count(perf_stall_count)
`endif
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one pending write entry, a pointer, and saturating counters.
    int          m_ptr, m_src;
    logic        m_valid, m_last;
    logic [4:0]  m_vd;
    logic [OW-1:0] m_off;
    logic [MW-1:0] m_mask;
    logic [DW-1:0] m_data;
    logic [2:0]  m_iidx;
    int          m_grants[N];
    int          m_drops, m_stalls;

    function automatic int pick();
        int j;
        for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (req_valid[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int w;
        w = pick();
        if (reset || w < 0 || !(!m_valid || vrfWriteRequest_ready)) return '0;
        return N'(1) << w;
    endfunction

    always @(posedge clock or posedge reset) begin : mdl
        int w;
        logic cl;
        if (reset) begin
            m_ptr = 0; m_src = 0; m_valid = 0; m_last = 0; m_vd = '0; m_off = '0;
            m_mask = '0; m_data = '0; m_iidx = '0; m_drops = 0; m_stalls = 0;
            for (int i = 0; i < N; i++) m_grants[i] = 0;
        end else begin
            w  = pick();
            cl = !m_valid || vrfWriteRequest_ready;
            if (m_valid && !vrfWriteRequest_ready && m_stalls < 65535) m_stalls++;
            if (m_valid && vrfWriteRequest_ready) m_valid = 0;
            if (w >= 0 && cl) begin
                m_ptr = (w + 1) % N;
                if (req_mask[w*MW +: MW] != '0) begin
                    m_valid = 1;
                    m_src   = w;
                    m_vd    = req_vd[w*5 +: 5];
                    m_off   = req_offset[w*OW +: OW];
                    m_mask  = req_mask[w*MW +: MW];
                    m_data  = req_data[w*DW +: DW];
                    m_last  = req_last[w];
                    m_iidx  = req_instructionIndex[w*3 +: 3];
                    if (m_grants[w] < 65535) m_grants[w]++;
                end else if (m_drops < 65535) begin
                    m_drops++;
                end
            end
        end
    end

    always @(negedge clock) begin
        chk("req_ready", req_ready, exp_ready());
        chk("out_valid", vrfWriteRequest_valid, m_valid);
        chk("out_vd", vrfWriteRequest_bits_vd, m_vd);
        chk("out_offset", vrfWriteRequest_bits_offset, m_off);
        chk("out_mask", vrfWriteRequest_bits_mask, m_mask);
        chk("out_data", vrfWriteRequest_bits_data, m_data);
        chk("out_last", vrfWriteRequest_bits_last, m_last);
        chk("out_iidx", vrfWriteRequest_bits_instructionIndex, m_iidx);
        chk("grant_source", grant_source, 64'(m_src));
`ifdef VRF_WRITE_ARB_PERF_EN
        for (int i = 0; i < N; i++) chk("perf_grant", perf_grant_count[i*16 +: 16], 64'(m_grants[i]));
        chk("perf_drop", perf_drop_count, 64'(m_drops));
        chk("perf_stall", perf_stall_count, 64'(m_stalls));
`endif
    end

    task automatic set_req(input int i, input logic v, input logic [MW-1:0] mk, input logic [DW-1:0] d);
        req_valid[i]                  = v;
        req_mask[i*MW +: MW]          = mk;
        req_data[i*DW +: DW]          = d;
        req_vd[i*5 +: 5]              = d[4:0];
        req_offset[i*OW +: OW]        = d[15:8];
        req_last[i]                   = d[0];
        req_instructionIndex[i*3 +: 3] = d[6:4];
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0; req_last = '0; req_vd = '0; req_offset = '0;
        req_mask = '0; req_data = '0; req_instructionIndex = '0;
        vrfWriteRequest_ready = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        #1;
        chk("rst_valid", vrfWriteRequest_valid, 0);
        chk("rst_src", grant_source, 0);

        // Fairness: all four requesting, ready high
        for (int i = 0; i < N; i++) set_req(i, 1'b1, MW'(1 << i), 32'hA000_0000 | 32'(i));
        vrfWriteRequest_ready = 1'b1;
        #1;
        chk("fair_ready0", req_ready, 4'b0001);
        for (int c = 0; c < 8; c++) begin
            step();
            chk("fair_src", grant_source, 64'(c % 4));
            chk("fair_valid", vrfWriteRequest_valid, 1);
        end

        // Backpressure: entry from req 3 held while ready low
        vrfWriteRequest_ready = 1'b0;
        #1;
        chk("bp_ready", req_ready, 4'b0000);
        repeat (3) begin
            step();
            chk("bp_src", grant_source, 3);
            chk("bp_data", vrfWriteRequest_bits_data, 32'hA000_0003);
            chk("bp_mask", vrfWriteRequest_bits_mask, 4'b1000);
        end
        vrfWriteRequest_ready = 1'b1;
        #1;
        chk("bp_release", req_ready, 4'b0001);
        step();
        chk("bp_next_src", grant_source, 0);
        chk("bp_next_data", vrfWriteRequest_bits_data, 32'hA000_0000);

        // Zero mask dropped; pointer moves past the dropper
        req_valid = '0;
        step();
        set_req(1, 1'b1, 4'h0, 32'hDEAD_BEEF);
        #1;
        chk("zm_ready", req_ready, 4'b0010);
        step();
        req_valid = '0;
        #1;
        chk("zm_no_write", vrfWriteRequest_valid, 0);
        set_req(1, 1'b1, 4'hF, 32'h1111_0001);
        set_req(2, 1'b1, 4'hF, 32'h2222_0002);
        #1;
        chk("zm_ptr2", req_ready, 4'b0100);
        step();
        chk("zm_src2", grant_source, 2);

        // Wrap: ptr = 3, req 0 and 3 valid
        req_valid = '0;
        set_req(0, 1'b1, 4'h3, 32'h0000_5A00);
        set_req(3, 1'b1, 4'hC, 32'h3333_A503);
        #1;
        chk("wrap_ready3", req_ready, 4'b1000);
        step();
        chk("wrap_src3", grant_source, 3);
        chk("wrap_ready0", req_ready, 4'b0001);
        step();
        chk("wrap_src0", grant_source, 0);
        req_valid = '0;
        step();

        // Reset mid-transfer
        set_req(0, 1'b1, 4'hF, 32'h7777_0070);
        vrfWriteRequest_ready = 1'b0;
        step();
        chk("pre_rst_valid", vrfWriteRequest_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", vrfWriteRequest_valid, 0);
        chk("mid_rst_ready", req_ready, 4'b0000);
        step();
        reset = 1'b0;
        set_req(1, 1'b1, 4'hF, 32'h8888_0081);
        #1;
        chk("post_rst_ptr0", req_ready, 4'b0001);
        req_valid = '0;
        set_req(2, 1'b1, 4'h5, 32'h9999_0092);
        #1;
        chk("post_rst_ready2", req_ready, 4'b0100);
        step();
        chk("post_rst_src", grant_source, 2);
        chk("post_rst_valid", vrfWriteRequest_valid, 1);
        chk("post_rst_data", vrfWriteRequest_bits_data, 32'h9999_0092);

        // Mixed traffic checked by the model every cycle
        repeat (300) begin
            for (int i = 0; i < N; i++)
                set_req(i, 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 3) == 0) ? 4'h0 : MW'($urandom), $urandom);
            vrfWriteRequest_ready = 1'($urandom_range(0, 2) != 0);
            step();
        end

`ifdef VRF_WRITE_ARB_PERF_EN
        req_valid = '0;
        set_req(0, 1'b1, 4'hF, 32'h0BAD_F00D);
        vrfWriteRequest_ready = 1'b1;
        step();
        req_valid = '0;
        vrfWriteRequest_ready = 1'b0;
        repeat (70000) @(posedge clock);
        #1;
        chk("perf_stall_sat", perf_stall_count, 16'hFFFF);
        step();
        chk("perf_stall_hold", perf_stall_count, 16'hFFFF);
        vrfWriteRequest_ready = 1'b1;
        step();
`endif

        req_valid = '0;
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
